// File: rtl/bg_scanline_sequencer.sv
// Background pipeline timing master: {col, bgno} slot counter, vcount row counter,
// blanking/status decode and registered display interrupt pulses.
module bg_scanline_sequencer #(
  parameter int unsigned H_TOTAL   = 308,
  parameter int unsigned H_VISIBLE = 240,
  parameter int unsigned V_TOTAL   = 228,
  parameter int unsigned V_VISIBLE = 160,
  parameter int unsigned NUM_SLOTS = 4
) (
  input  logic       clock,
  input  logic       rst_b,
  input  logic [7:0] dispstat_lyc,
  input  logic [2:0] irq_en,
  input  logic       forced_blank,
  output logic [8:0] col,
  output logic [1:0] bgno,
  output logic [7:0] vcount,
  output logic       start_row,
  output logic       new_frame,
  output logic       hblank,
  output logic       vblank,
  output logic       vcount_match,
  output logic       render_active,
  output logic [2:0] dispstat_status,
  output logic       irq_vblank,
  output logic       irq_hblank,
  output logic       irq_vcount
);

  localparam int unsigned COL_W  = 9;
  localparam int unsigned SLOT_W = 2;
  localparam int unsigned LINE_W = 8;

  logic last_slot;
  logic last_line;
  logic vblank_trig;
  logic hblank_trig;
  logic prev_match;

  assign last_slot = (bgno == SLOT_W'(NUM_SLOTS - 1));
  assign last_line = (vcount == LINE_W'(V_TOTAL - 1));

  assign start_row = (col == COL_W'(H_TOTAL - 1)) && last_slot;
  assign new_frame = start_row && last_line;

  // Zero-latency decode from the counter registers and live register inputs
  assign hblank          = (col >= COL_W'(H_VISIBLE));
  assign vblank          = (vcount >= LINE_W'(V_VISIBLE)) && (vcount <= LINE_W'(V_TOTAL - 2));
  assign vcount_match    = (vcount == dispstat_lyc);
  assign render_active   = !hblank && !vblank && !forced_blank;
  assign dispstat_status = {vcount_match, hblank, vblank};

  assign vblank_trig = (col == '0) && (bgno == '0) && (vcount == LINE_W'(V_VISIBLE));
  assign hblank_trig = (col == COL_W'(H_VISIBLE)) && (bgno == '0);

  // Slot/column/line counters; a line wrap overrides the ordinary slot increment
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      col    <= '0;
      bgno   <= '0;
      vcount <= '0;
    end else if (start_row) begin
      col    <= '0;
      bgno   <= '0;
      vcount <= last_line ? '0 : vcount + LINE_W'(1);
    end else if (last_slot) begin
      col  <= col + COL_W'(1);
      bgno <= '0;
    end else begin
      bgno <= bgno + SLOT_W'(1);
    end
  end

  // Interrupt pulses land one clock after their trigger; enables sampled on the trigger clock
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      prev_match <= 1'b0;
      irq_vblank <= 1'b0;
      irq_hblank <= 1'b0;
      irq_vcount <= 1'b0;
    end else begin
      prev_match <= vcount_match;
      irq_vblank <= irq_en[0] && vblank_trig;
      irq_hblank <= irq_en[1] && hblank_trig;
      irq_vcount <= irq_en[2] && vcount_match && !prev_match;
    end
  end

endmodule

// File: tb/tb_bg_scanline_sequencer.sv
// Directed bench: a full-size instance for line/vcount timing and a shrunken-geometry
// instance for whole-frame, vblank and mid-frame reset behaviour.
module tb_bg_scanline_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_b_d, rst_b_s;
  logic [7:0] lyc_d, lyc_s;
  logic [2:0] irq_en_d, irq_en_s;
  logic       forced_blank;

  logic [8:0] col_d, col_s;
  logic [1:0] bgno_d, bgno_s;
  logic [7:0] vcount_d, vcount_s;
  logic       start_row_d, start_row_s, new_frame_d, new_frame_s;
  logic       hblank_d, hblank_s, vblank_d, vblank_s;
  logic       match_d, match_s, render_d, render_s;
  logic [2:0] status_d, status_s;
  logic       irq_vb_d, irq_vb_s, irq_hb_d, irq_hb_s, irq_vc_d, irq_vc_s;

  bg_scanline_sequencer dut_d (
    .clock(clock), .rst_b(rst_b_d), .dispstat_lyc(lyc_d), .irq_en(irq_en_d),
    .forced_blank(forced_blank), .col(col_d), .bgno(bgno_d), .vcount(vcount_d),
    .start_row(start_row_d), .new_frame(new_frame_d), .hblank(hblank_d), .vblank(vblank_d),
    .vcount_match(match_d), .render_active(render_d), .dispstat_status(status_d),
    .irq_vblank(irq_vb_d), .irq_hblank(irq_hb_d), .irq_vcount(irq_vc_d)
  );

  bg_scanline_sequencer #(
    .H_TOTAL(20), .H_VISIBLE(15), .V_TOTAL(10), .V_VISIBLE(6), .NUM_SLOTS(4)
  ) dut_s (
    .clock(clock), .rst_b(rst_b_s), .dispstat_lyc(lyc_s), .irq_en(irq_en_s),
    .forced_blank(forced_blank), .col(col_s), .bgno(bgno_s), .vcount(vcount_s),
    .start_row(start_row_s), .new_frame(new_frame_s), .hblank(hblank_s), .vblank(vblank_s),
    .vcount_match(match_s), .render_active(render_s), .dispstat_status(status_s),
    .irq_vblank(irq_vb_s), .irq_hblank(irq_hb_s), .irq_vcount(irq_vc_s)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    int pulses;
    int misses;
    int pos;
    int line;
    int prev;
    logic exp_hb;
    logic exp_vb;

    rst_b_d = 1'b0; rst_b_s = 1'b0;
    lyc_d = 8'd0; lyc_s = 8'hFF;
    irq_en_d = 3'b000; irq_en_s = 3'b000;
    forced_blank = 1'b0;

    // Reset state and combinational outputs during reset
    repeat (3) @(posedge clock);
    #1;
    check("rst_col", 32'(col_d), 0);
    check("rst_bgno", 32'(bgno_d), 0);
    check("rst_vcount", 32'(vcount_d), 0);
    check("rst_start_row", 32'(start_row_d), 0);
    check("rst_new_frame", 32'(new_frame_d), 0);
    check("rst_hblank", 32'(hblank_d), 0);
    check("rst_vblank", 32'(vblank_d), 0);
    check("rst_render", 32'(render_d), 1);
    check("rst_match_lyc0", 32'(match_d), 1);
    check("rst_irqs", 32'({irq_vb_d, irq_hb_d, irq_vc_d}), 0);
    forced_blank = 1'b1;
    #1 check("rst_render_forced", 32'(render_d), 0);
    forced_blank = 1'b0;
    lyc_d = 8'd200;
    #1 check("rst_match_lyc200", 32'(match_d), 0);

    // First few clocks after release
    rst_b_d = 1'b1;
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("early_flags@%0d", cyc),
            32'({start_row_d, hblank_d, vblank_d, irq_vb_d, irq_hb_d, irq_vc_d}), 0);
    end
    check("c5_col", 32'(col_d), 1);
    check("c5_bgno", 32'(bgno_d), 1);
    check("c5_vcount", 32'(vcount_d), 0);

    // hblank entry and irq_hblank pulse
    irq_en_d = 3'b010;
    while (cyc < 959) tick();
    check("c959_hblank", 32'(hblank_d), 0);
    check("c959_col", 32'({col_d, bgno_d}), 32'({9'd239, 2'd3}));
    tick();
    check("c960_hblank", 32'(hblank_d), 1);
    check("c960_col", 32'({col_d, bgno_d}), 32'({9'd240, 2'd0}));
    check("c960_irq_hb", 32'(irq_hb_d), 0);
    check("c960_status", 32'(status_d), 3'b010);
    check("c960_render", 32'(render_d), 0);
    tick();
    check("c961_irq_hb", 32'(irq_hb_d), 1);
    tick();
    check("c962_irq_hb", 32'(irq_hb_d), 0);
    while (cyc < 1231) tick();
    check("c1231_start_row", 32'(start_row_d), 1);
    check("c1231_new_frame", 32'(new_frame_d), 0);
    check("c1231_pos", 32'({col_d, bgno_d, vcount_d}), 32'({9'd307, 2'd3, 8'd0}));
    tick();
    check("c1232_pos", 32'({col_d, bgno_d, vcount_d}), 32'({9'd0, 2'd0, 8'd1}));
    check("c1232_hblank", 32'(hblank_d), 0);
    check("c1232_start_row", 32'(start_row_d), 0);

    // vcount compare on line 5
    irq_en_d = 3'b100;
    lyc_d = 8'd5;
    while (cyc < 6159) tick();
    check("l4_vcount", 32'(vcount_d), 4);
    check("l4_match", 32'(match_d), 0);
    tick();
    check("l5_vcount", 32'(vcount_d), 5);
    check("l5_match", 32'(match_d), 1);
    check("l5_status", 32'(status_d), 3'b100);
    check("l5_irq_vc_trig", 32'(irq_vc_d), 0);
    tick();
    check("l5_irq_vc_pulse", 32'(irq_vc_d), 1);
    pulses = 0;
    misses = 0;
    while (cyc < 7391) begin
      tick();
      if (irq_vc_d) pulses++;
      if (!match_d) misses++;
    end
    check("l5_extra_irq_vc", 32'(pulses), 0);
    check("l5_match_drop", 32'(misses), 0);
    tick();
    check("l6_vcount", 32'(vcount_d), 6);
    check("l6_match", 32'(match_d), 0);

    // Rewriting lyc to the current line fires irq_vcount
    while (cyc < 8700) tick();
    check("l7_vcount", 32'(vcount_d), 7);
    check("l7_match_before", 32'(match_d), 0);
    lyc_d = 8'd7;
    #1;
    check("l7_match_now", 32'(match_d), 1);
    check("l7_irq_vc_trig", 32'(irq_vc_d), 0);
    tick();
    check("l7_irq_vc_pulse", 32'(irq_vc_d), 1);
    tick();
    check("l7_irq_vc_end", 32'(irq_vc_d), 0);

    // forced_blank only gates render_active
    forced_blank = 1'b1;
    #1 check("fb_render", 32'(render_d), 0);
    tick();
    check("fb_counting", 32'({col_d, bgno_d, vcount_d}), 32'({9'd19, 2'd3, 8'd7}));
    forced_blank = 1'b0;
    #1 check("fb_render_off", 32'(render_d), 1);

    // Shrunken geometry: 80-clock lines, 10 lines, vblank on lines 6..8
    irq_en_s = 3'b011;
    rst_b_s = 1'b1;
    cyc = 0;
    while (cyc < 800) begin
      tick();
      pos = cyc % 80;
      line = (cyc % 800) / 80;
      prev = cyc - 1;
      exp_hb = (pos / 4) >= 15;
      exp_vb = (line >= 6) && (line <= 8);
      check($sformatf("s_pos@%0d", cyc), 32'({col_s, bgno_s, vcount_s}),
            32'({9'(pos / 4), 2'(pos % 4), 8'(line)}));
      check($sformatf("s_hblank@%0d", cyc), 32'(hblank_s), 32'(exp_hb));
      check($sformatf("s_vblank@%0d", cyc), 32'(vblank_s), 32'(exp_vb));
      check($sformatf("s_render@%0d", cyc), 32'(render_s), 32'(!exp_hb && !exp_vb));
      check($sformatf("s_status@%0d", cyc), 32'(status_s), 32'({1'b0, exp_hb, exp_vb}));
      check($sformatf("s_start_row@%0d", cyc), 32'(start_row_s), 32'(pos == 79));
      check($sformatf("s_new_frame@%0d", cyc), 32'(new_frame_s), 32'((cyc % 800) == 799));
      check($sformatf("s_irq_vb@%0d", cyc), 32'(irq_vb_s), 32'((prev % 800) == 480));
      check($sformatf("s_irq_hb@%0d", cyc), 32'(irq_hb_s), 32'((prev % 80) == 60));
    end

    // Mid-frame asynchronous reset
    while (cyc < 1060) tick();
    check("s_pre_rst_pos", 32'({col_s, vcount_s}), 32'({9'd5, 8'd3}));
    irq_en_s = 3'b100;
    lyc_s = 8'd0;
    #1 check("s_pre_rst_match", 32'(match_s), 0);
    rst_b_s = 1'b0;
    #1;
    check("s_rst_pos", 32'({col_s, bgno_s, vcount_s}), 0);
    check("s_rst_match", 32'(match_s), 1);
    check("s_rst_irqs", 32'({irq_vb_s, irq_hb_s, irq_vc_s}), 0);
    tick();
    tick();
    check("s_rst_hold_pos", 32'({col_s, bgno_s, vcount_s}), 0);
    check("s_rst_hold_irqs", 32'({irq_vb_s, irq_hb_s, irq_vc_s}), 0);
    rst_b_s = 1'b1;
    cyc = 0;
    #1 check("s_rel_irqs", 32'({irq_vb_s, irq_hb_s, irq_vc_s}), 0);
    tick();
    check("s_rel_irq_vc", 32'(irq_vc_s), 1);
    check("s_rel_other_irqs", 32'({irq_vb_s, irq_hb_s}), 0);
    check("s_rel_pos", 32'({col_s, bgno_s, vcount_s}), 32'({9'd0, 2'd1, 8'd0}));
    pulses = 0;
    while (cyc < 79) begin
      tick();
      if (irq_vc_s) pulses++;
    end
    check("s_rel_no_repeat", 32'(pulses), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
